// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
//   slave  : the controller side (reads hazard sources, drives stall/flush enables and counters)
//   master : the datapath side (drives hazard sources, reads stall/flush enables and counters)
// id_ex_rs1_addr/id_ex_rs2_addr travel with the bundle for the forwarding unit; the stall
// controller itself only needs the EX destination and the ID sources.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned CNT_WIDTH      = 32
);
  logic [REG_ADDR_WIDTH-1:0] id_ex_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] id_ex_rs2_addr;
  logic [REG_ADDR_WIDTH-1:0] id_ex_rd_addr;
  logic                      id_ex_mem_read;
  logic                      id_ex_valid;
  logic [REG_ADDR_WIDTH-1:0] if_id_rs1_addr;
  logic [REG_ADDR_WIDTH-1:0] if_id_rs2_addr;
  logic                      branch_taken;
  logic                      md_start;
  logic                      md_done;
  logic                      mem_req;
  logic                      mem_ready;
  logic                      pc_stall;
  logic                      if_id_stall;
  logic                      id_ex_stall;
  logic                      ex_mem_stall;
  logic                      if_id_flush;
  logic                      id_ex_flush;
  logic                      ex_mem_flush;
  logic                      mem_wb_flush;
  logic [CNT_WIDTH-1:0]      stall_cycles;
  logic [CNT_WIDTH-1:0]      flush_count;

  modport master (
    output id_ex_rs1_addr, id_ex_rs2_addr, id_ex_rd_addr, id_ex_mem_read, id_ex_valid,
           if_id_rs1_addr, if_id_rs2_addr, branch_taken, md_start, md_done, mem_req, mem_ready,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, stall_cycles, flush_count
  );

  modport slave (
    input  id_ex_rd_addr, id_ex_mem_read, id_ex_valid, if_id_rs1_addr, if_id_rs2_addr,
           branch_taken, md_start, md_done, mem_req, mem_ready,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Sequential stall/flush controller for the 5-stage pipeline.
// Handles data-memory wait freezes, mul/div busy stalls, branch redirects and
// multi-bubble load-use hazards, plus saturating stall/flush counters.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset; forces all outputs low while asserted
//   bus   : hazard bundle (slave side) -- hazard sources in, stall/flush enables
//           (combinational, same cycle) and perf counters (registered) out
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_ADDR_WIDTH   = 5,
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned CNT_WIDTH        = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  pipeline_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StLuStall, StMdBusy} state_e;

  localparam logic [2:0] LuInit = 3'(LOAD_USE_BUBBLES - 1);

  state_e                    r_state, w_state_nxt;
  logic [2:0]                r_lu_cnt, w_lu_cnt_nxt;
  logic [CNT_WIDTH-1:0]      r_stall_cycles;
  logic [CNT_WIDTH-1:0]      r_flush_count;

  logic [REG_ADDR_WIDTH-1:0] w_rd;
  logic                      w_mem_wait;
  logic                      w_load_use;
  logic                      w_md_stall;
  logic                      w_branch_apply;
  logic                      w_pc_stall, w_if_id_stall, w_id_ex_stall, w_ex_mem_stall;
  logic                      w_if_id_flush, w_id_ex_flush, w_ex_mem_flush, w_mem_wb_flush;

  assign w_rd       = bus.id_ex_rd_addr;
  assign w_mem_wait = bus.mem_req && !bus.mem_ready;
  // x0 as the load destination can never create a dependency.
  assign w_load_use = bus.id_ex_valid && bus.id_ex_mem_read && (w_rd != '0) &&
                      ((w_rd == bus.if_id_rs1_addr) || (w_rd == bus.if_id_rs2_addr));
  // A start that completes in the same cycle never stalls.
  assign w_md_stall = !bus.md_done &&
                      (((r_state == StIdle) && bus.md_start) || (r_state == StMdBusy));

  always_comb begin
    w_state_nxt    = r_state;
    w_lu_cnt_nxt   = r_lu_cnt;
    w_branch_apply = 1'b0;
    w_pc_stall     = 1'b0;
    w_if_id_stall  = 1'b0;
    w_id_ex_stall  = 1'b0;
    w_ex_mem_stall = 1'b0;
    w_if_id_flush  = 1'b0;
    w_id_ex_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    w_mem_wb_flush = 1'b0;

    if (w_mem_wait) begin
      // Full freeze: state, bubble count and any pending redirect wait for release.
      w_pc_stall     = 1'b1;
      w_if_id_stall  = 1'b1;
      w_id_ex_stall  = 1'b1;
      w_ex_mem_stall = 1'b1;
      w_mem_wb_flush = 1'b1;
    end else if (w_md_stall) begin
      w_pc_stall     = 1'b1;
      w_if_id_stall  = 1'b1;
      w_id_ex_stall  = 1'b1;
      w_ex_mem_flush = 1'b1;
      w_state_nxt    = StMdBusy;
    end else if (bus.branch_taken) begin
      // Redirect squashes the younger instructions, including any load-use victim.
      w_if_id_flush  = 1'b1;
      w_id_ex_flush  = 1'b1;
      w_branch_apply = 1'b1;
      w_state_nxt    = StIdle;
      w_lu_cnt_nxt   = '0;
    end else if (r_state == StLuStall) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
      if (r_lu_cnt <= 3'd1) begin
        w_state_nxt  = StIdle;
        w_lu_cnt_nxt = '0;
      end else begin
        w_lu_cnt_nxt = r_lu_cnt - 3'd1;
      end
    end else if ((r_state == StIdle) && w_load_use) begin
      w_pc_stall    = 1'b1;
      w_if_id_stall = 1'b1;
      w_id_ex_flush = 1'b1;
      if (LOAD_USE_BUBBLES > 1) begin
        w_state_nxt  = StLuStall;
        w_lu_cnt_nxt = LuInit;
      end
    end else if (r_state == StMdBusy) begin
      // md_done: result advances this cycle without a stall.
      w_state_nxt = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_lu_cnt       <= '0;
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_lu_cnt <= w_lu_cnt_nxt;
      if (w_pc_stall && (r_stall_cycles != {CNT_WIDTH{1'b1}})) begin
        r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
      end
      if (w_branch_apply && (r_flush_count != {CNT_WIDTH{1'b1}})) begin
        r_flush_count <= r_flush_count + CNT_WIDTH'(1);
      end
    end
  end

  // Outputs are gated so they read low for the whole time reset is held.
  assign bus.pc_stall     = rst_n && w_pc_stall;
  assign bus.if_id_stall  = rst_n && w_if_id_stall;
  assign bus.id_ex_stall  = rst_n && w_id_ex_stall;
  assign bus.ex_mem_stall = rst_n && w_ex_mem_stall;
  assign bus.if_id_flush  = rst_n && w_if_id_flush;
  assign bus.id_ex_flush  = rst_n && w_id_ex_flush;
  assign bus.ex_mem_flush = rst_n && w_ex_mem_flush;
  assign bus.mem_wb_flush = rst_n && w_mem_wb_flush;
  assign bus.stall_cycles = r_stall_cycles;
  assign bus.flush_count  = r_flush_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  logic clk;
  logic rst_n;

  pipeline_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) if1 ();
  pipeline_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) if3 ();
  pipeline_hazard_ctrl_if #(.REG_ADDR_WIDTH(5), .CNT_WIDTH(2))  ifs ();

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(5), .LOAD_USE_BUBBLES(1), .CNT_WIDTH(32)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1)
  );
  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(5), .LOAD_USE_BUBBLES(3), .CNT_WIDTH(32)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3)
  );
  // Narrow-counter copy fed with the same stimulus as u_dut1 to reach saturation quickly.
  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(5), .LOAD_USE_BUBBLES(1), .CNT_WIDTH(2)) u_duts (
    .clk(clk), .rst_n(rst_n), .bus(ifs)
  );

  assign ifs.id_ex_rs1_addr = if1.id_ex_rs1_addr;
  assign ifs.id_ex_rs2_addr = if1.id_ex_rs2_addr;
  assign ifs.id_ex_rd_addr  = if1.id_ex_rd_addr;
  assign ifs.id_ex_mem_read = if1.id_ex_mem_read;
  assign ifs.id_ex_valid    = if1.id_ex_valid;
  assign ifs.if_id_rs1_addr = if1.if_id_rs1_addr;
  assign ifs.if_id_rs2_addr = if1.if_id_rs2_addr;
  assign ifs.branch_taken   = if1.branch_taken;
  assign ifs.md_start       = if1.md_start;
  assign ifs.md_done        = if1.md_done;
  assign ifs.mem_req        = if1.mem_req;
  assign ifs.mem_ready      = if1.mem_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       mr;
    logic       vld;
    logic       br;
    logic       ms;
    logic       md;
    logic       mq;
    logic       my;
  } vin_t;

  // exp = {pc_st, if_id_st, id_ex_st, ex_mem_st, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl}
  typedef struct {
    vin_t       in;
    logic [7:0] exp;
  } vec_t;

  int pass_cnt = 0;
  int total    = 0;
  int st1 = 0, fl1 = 0, st3 = 0, fl3 = 0;
  vec_t tbl[15];
  vin_t zero_in, lu_in;

  function automatic vin_t mk_in(input logic [4:0] rd, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic mr, input logic vld,
                                 input logic br, input logic ms, input logic md,
                                 input logic mq, input logic my);
    vin_t v;
    v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.mr = mr; v.vld = vld;
    v.br = br; v.ms = ms; v.md = md; v.mq = mq; v.my = my;
    return v;
  endfunction

  function automatic vec_t mk_vec(input vin_t v, input logic [7:0] exp);
    vec_t r;
    r.in  = v;
    r.exp = exp;
    return r;
  endfunction

  function automatic logic [7:0] out1();
    return {if1.pc_stall, if1.if_id_stall, if1.id_ex_stall, if1.ex_mem_stall,
            if1.if_id_flush, if1.id_ex_flush, if1.ex_mem_flush, if1.mem_wb_flush};
  endfunction

  function automatic logic [7:0] out3();
    return {if3.pc_stall, if3.if_id_stall, if3.id_ex_stall, if3.ex_mem_stall,
            if3.if_id_flush, if3.id_ex_flush, if3.ex_mem_flush, if3.mem_wb_flush};
  endfunction

  function automatic int sat3(input int n);
    return (n > 3) ? 3 : n;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic drv1(input vin_t v);
    if1.id_ex_rs1_addr = 5'd1;
    if1.id_ex_rs2_addr = 5'd2;
    if1.id_ex_rd_addr  = v.rd;
    if1.if_id_rs1_addr = v.rs1;
    if1.if_id_rs2_addr = v.rs2;
    if1.id_ex_mem_read = v.mr;
    if1.id_ex_valid    = v.vld;
    if1.branch_taken   = v.br;
    if1.md_start       = v.ms;
    if1.md_done        = v.md;
    if1.mem_req        = v.mq;
    if1.mem_ready      = v.my;
  endtask

  task automatic drv3(input vin_t v);
    if3.id_ex_rs1_addr = 5'd1;
    if3.id_ex_rs2_addr = 5'd2;
    if3.id_ex_rd_addr  = v.rd;
    if3.if_id_rs1_addr = v.rs1;
    if3.if_id_rs2_addr = v.rs2;
    if3.id_ex_mem_read = v.mr;
    if3.id_ex_valid    = v.vld;
    if3.branch_taken   = v.br;
    if3.md_start       = v.ms;
    if3.md_done        = v.md;
    if3.mem_req        = v.mq;
    if3.mem_ready      = v.my;
  endtask

  // Inputs are applied at a negedge; outputs are checked 1 time unit later and the
  // expected counters advance as the following posedge would.
  task automatic step1(input string nm, input logic [7:0] exp);
    #1;
    chk(nm, {24'd0, out1()}, {24'd0, exp});
    if (exp[7]) st1++;
    if (exp[3]) fl1++;
    @(negedge clk);
  endtask

  task automatic step3(input string nm, input logic [7:0] exp);
    #1;
    chk(nm, {24'd0, out3()}, {24'd0, exp});
    if (exp[7]) st3++;
    if (exp[3]) fl3++;
    @(negedge clk);
  endtask

  task automatic chk_cnt1(input string nm);
    chk({nm, "_stall1"}, if1.stall_cycles, st1);
    chk({nm, "_flush1"}, if1.flush_count, fl1);
    chk({nm, "_stall_sat"}, {30'd0, ifs.stall_cycles}, sat3(st1));
    chk({nm, "_flush_sat"}, {30'd0, ifs.flush_count}, sat3(fl1));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    st1 = 0; fl1 = 0; st3 = 0; fl3 = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    zero_in = mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lu_in   = mk_in(5, 5, 1, 1, 1, 0, 0, 0, 0, 0);

    tbl[0]  = mk_vec(zero_in, 8'h00);
    tbl[1]  = mk_vec(lu_in, 8'hC4);                                    // rd == rs1
    tbl[2]  = mk_vec(mk_in(7, 3, 7, 1, 1, 0, 0, 0, 0, 0), 8'hC4);      // rd == rs2
    tbl[3]  = mk_vec(mk_in(0, 0, 0, 1, 1, 0, 0, 0, 0, 0), 8'h00);      // x0 dest
    tbl[4]  = mk_vec(mk_in(5, 5, 5, 1, 0, 0, 0, 0, 0, 0), 8'h00);      // not valid
    tbl[5]  = mk_vec(mk_in(5, 5, 5, 0, 1, 0, 0, 0, 0, 0), 8'h00);      // not a load
    tbl[6]  = mk_vec(mk_in(5, 6, 7, 1, 1, 0, 0, 0, 0, 0), 8'h00);      // no match
    tbl[7]  = mk_vec(mk_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0), 8'h0C);      // branch
    tbl[8]  = mk_vec(mk_in(5, 5, 1, 1, 1, 1, 0, 0, 0, 0), 8'h0C);      // branch beats load-use
    tbl[9]  = mk_vec(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), 8'hF1);      // mem wait
    tbl[10] = mk_vec(mk_in(5, 5, 1, 1, 1, 1, 0, 0, 1, 0), 8'hF1);      // mem wait beats all
    tbl[11] = mk_vec(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), 8'h00);      // mem ready
    tbl[12] = mk_vec(mk_in(0, 0, 0, 0, 0, 0, 1, 1, 0, 0), 8'h00);      // md start+done
    tbl[13] = mk_vec(zero_in, 8'h00);                                  // still idle after it
    tbl[14] = mk_vec(mk_in(5, 5, 1, 1, 1, 0, 0, 0, 1, 1), 8'hC4);      // load-use, mem ready

    rst_n = 1'b0;
    drv1(lu_in);
    drv3(lu_in);
    @(negedge clk);
    #1;
    chk("reset_out1", {24'd0, out1()}, 32'd0);
    chk("reset_out3", {24'd0, out3()}, 32'd0);
    chk("reset_stall1", if1.stall_cycles, 32'd0);
    chk("reset_flush1", if1.flush_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drv1(zero_in);
    drv3(zero_in);

    for (int i = 0; i < 15; i++) begin
      drv1(tbl[i].in);
      step1($sformatf("vec%0d", i), tbl[i].exp);
    end
    drv1(zero_in);
    chk_cnt1("table");

    // Single-bubble load-use
    do_reset();
    drv1(lu_in);
    step1("t1_lu", 8'hC4);
    drv1(zero_in);
    step1("t1_after", 8'h00);
    chk("t1_stall_cycles", if1.stall_cycles, 32'd1);

    // Mul/div busy for 8 cycles, then done
    drv1(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    for (int i = 0; i < 8; i++) step1($sformatf("t3_busy%0d", i), 8'hE2);
    drv1(mk_in(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
    step1("t3_done", 8'h00);
    drv1(zero_in);
    step1("t3_idle", 8'h00);
    chk("t3_stall_cycles", if1.stall_cycles, 32'd9);

    // Branch and load-use together
    do_reset();
    drv1(mk_in(5, 5, 1, 1, 1, 1, 0, 0, 0, 0));
    step1("t5_br_lu", 8'h0C);
    drv1(zero_in);
    chk("t5_flush_count", if1.flush_count, 32'd1);
    chk("t5_stall_cycles", if1.stall_cycles, 32'd0);

    // Branch held across a mem wait is applied on the release cycle
    drv1(mk_in(0, 0, 0, 0, 0, 1, 0, 0, 1, 0));
    step1("tf_wait_br", 8'hF1);
    drv1(mk_in(0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    step1("tf_release_br", 8'h0C);
    drv1(zero_in);
    step1("tf_idle", 8'h00);
    chk_cnt1("tf");

    // Three-bubble load-use
    drv3(lu_in);
    step3("t2_b1", 8'hC4);
    drv3(zero_in);
    step3("t2_b2", 8'hC4);
    step3("t2_b3", 8'hC4);
    step3("t2_idle", 8'h00);

    // Mem wait in the middle of the load-use bubbles
    drv3(lu_in);
    step3("t4_b1", 8'hC4);
    drv3(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++) step3($sformatf("t4_freeze%0d", i), 8'hF1);
    drv3(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    step3("t4_b2", 8'hC4);
    drv3(zero_in);
    step3("t4_b3", 8'hC4);
    step3("t4_idle", 8'h00);

    // Branch cuts the bubble sequence short
    drv3(lu_in);
    step3("te_b1", 8'hC4);
    drv3(mk_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    step3("te_branch", 8'h0C);
    drv3(zero_in);
    step3("te_idle", 8'h00);
    chk("t3b_stall_cycles", if3.stall_cycles, st3);
    chk("t3b_flush_count", if3.flush_count, fl3);

    // Reset asserted mid MD_BUSY
    drv1(mk_in(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    step1("t6_busy0", 8'hE2);
    step1("t6_busy1", 8'hE2);
    #2;
    rst_n = 1'b0;
    st1 = 0; fl1 = 0; st3 = 0; fl3 = 0;
    #1;
    chk("t6_rst_out", {24'd0, out1()}, 32'd0);
    chk("t6_rst_stall", if1.stall_cycles, 32'd0);
    chk("t6_rst_flush", if1.flush_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drv1(zero_in);
    step1("t6_idle", 8'h00);
    drv1(mk_in(0, 0, 0, 1, 1, 0, 0, 0, 0, 0));
    step1("t6_x0_load", 8'h00);
    drv1(zero_in);
    chk_cnt1("t6");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
